// File: rtl/rd3_pkg.sv
// Shared width helpers and the sqrt(3)/2 coefficient for the pipelined radix-3 butterfly.
package rd3_pkg;

  localparam int COEF_FRAC_DEF = 10;

  function automatic int dw_of(input int sign_bit, input int int_bit, input int flt_bit);
    return sign_bit + int_bit + flt_bit;
  endfunction

  // Two guard bits cover the worst-case growth of a+b+c.
  function automatic int ow_of(input int dw);
    return dw + 2;
  endfunction

  function automatic longint isqrt(input longint v);
    longint r;
    longint b;
    longint x;
    r = 0;
    x = v;
    b = longint'(1) << 62;
    while (b > x) b = b >> 2;
    while (b != 0) begin
      if (x >= r + b) begin
        x = x - (r + b);
        r = (r >> 1) + b;
      end else begin
        r = r >> 1;
      end
      b = b >> 2;
    end
    return r;
  endfunction

  // round(sqrt(3)/2 * 2^cf) == (floor(sqrt(3 * 4^cf)) + 1) / 2
  function automatic int c_sq3h(input int cf);
    return int'((isqrt(3 * (longint'(1) << (2 * cf))) + 1) >> 1);
  endfunction

  function automatic int rnd_ofs(input int cf);
    return 1 << (cf - 1);
  endfunction

  localparam int C_SQ3H = c_sq3h(COEF_FRAC_DEF);

endpackage

// File: rtl/rd3_const_mult.sv
// Signed multiply by sqrt(3)/2: product registered here, round-half-up shift on the way out.
module rd3_const_mult
  import rd3_pkg::*;
#(
  parameter int OW        = 15,
  parameter int COEF_FRAC = COEF_FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic signed [OW-1:0] d,
  output logic signed [OW-1:0] t
);

  localparam int PW = OW + COEF_FRAC + 1;
  localparam logic signed [PW-1:0] C_K   = PW'(c_sq3h(COEF_FRAC));
  localparam logic signed [PW-1:0] RND_K = PW'(rnd_ofs(COEF_FRAC));

  logic signed [PW-1:0] p_d, p_q, p_rnd;

  always_comb begin
    p_d = p_q;
    if (en) p_d = PW'(d) * C_K;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) p_q <= '0;
    else        p_q <= p_d;
  end

  assign p_rnd = p_q + RND_K;
  assign t     = OW'(p_rnd >>> COEF_FRAC);

endmodule

// File: rtl/rd3bf_pipe.sv
// Three-stage pipelined 3-point DFT with forward/inverse select, tag side-band and valid/ready flow.
// Handshake: a beat moves on valid & ready; en = ~do_vld | do_rdy advances every stage (bubbles included), di_rdy = en.
module rd3bf_pipe
  import rd3_pkg::*;
#(
  parameter int SIGN_BIT  = 1,
  parameter int INT_BIT   = 6,
  parameter int FLT_BIT   = 6,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int TAG_W     = 4,
  localparam int DW = dw_of(SIGN_BIT, INT_BIT, FLT_BIT),
  localparam int OW = ow_of(DW)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             di_vld,
  output logic             di_rdy,
  input  logic             di_inv,
  input  logic [TAG_W-1:0] di_tag,
  input  logic [DW-1:0]    in1_re,
  input  logic [DW-1:0]    in1_im,
  input  logic [DW-1:0]    in2_re,
  input  logic [DW-1:0]    in2_im,
  input  logic [DW-1:0]    in3_re,
  input  logic [DW-1:0]    in3_im,
  output logic [OW-1:0]    out1_re,
  output logic [OW-1:0]    out1_im,
  output logic [OW-1:0]    out2_re,
  output logic [OW-1:0]    out2_im,
  output logic [OW-1:0]    out3_re,
  output logic [OW-1:0]    out3_im,
  output logic             do_vld,
  input  logic             do_rdy,
  output logic             do_inv,
  output logic [TAG_W-1:0] do_tag
);

  logic en;
  logic signed [OW-1:0] a_re, a_im, b_re, b_im, c_re, c_im;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic inv1_d, inv1_q, inv2_d, inv2_q, inv3_d, inv3_q;
  logic [TAG_W-1:0] tag1_d, tag1_q, tag2_d, tag2_q, tag3_d, tag3_q;
  logic signed [OW-1:0] a1_re_d, a1_re_q, a1_im_d, a1_im_q;
  logic signed [OW-1:0] s1_re_d, s1_re_q, s1_im_d, s1_im_q;
  logic signed [OW-1:0] d1_re_d, d1_re_q, d1_im_d, d1_im_q;
  logic signed [OW-1:0] x0_re_d, x0_re_q, x0_im_d, x0_im_q;
  logic signed [OW-1:0] m_re_d, m_re_q, m_im_d, m_im_q;
  logic signed [OW-1:0] t_re, t_im;
  logic signed [OW-1:0] f1_re, f1_im, f2_re, f2_im;
  logic [OW-1:0] o1_re_d, o1_re_q, o1_im_d, o1_im_q;
  logic [OW-1:0] o2_re_d, o2_re_q, o2_im_d, o2_im_q;
  logic [OW-1:0] o3_re_d, o3_re_q, o3_im_d, o3_im_q;

  assign en     = ~v3_q | do_rdy;
  assign di_rdy = en;

  assign a_re = OW'($signed(in1_re));
  assign a_im = OW'($signed(in1_im));
  assign b_re = OW'($signed(in2_re));
  assign b_im = OW'($signed(in2_im));
  assign c_re = OW'($signed(in3_re));
  assign c_im = OW'($signed(in3_im));

  // The product register inside each multiplier is the S2 stage of d.
  rd3_const_mult #(.OW(OW), .COEF_FRAC(COEF_FRAC)) u_mult_re (
    .clk(clk), .n_rst(n_rst), .en(en), .d(d1_re_q), .t(t_re)
  );
  rd3_const_mult #(.OW(OW), .COEF_FRAC(COEF_FRAC)) u_mult_im (
    .clk(clk), .n_rst(n_rst), .en(en), .d(d1_im_q), .t(t_im)
  );

  // Forward-mode X1/X2; inverse just swaps them.
  assign f1_re = m_re_q + t_im;
  assign f1_im = m_im_q - t_re;
  assign f2_re = m_re_q - t_im;
  assign f2_im = m_im_q + t_re;

  always_comb begin
    v1_d = v1_q;   inv1_d = inv1_q;   tag1_d = tag1_q;
    a1_re_d = a1_re_q; a1_im_d = a1_im_q;
    s1_re_d = s1_re_q; s1_im_d = s1_im_q;
    d1_re_d = d1_re_q; d1_im_d = d1_im_q;
    v2_d = v2_q;   inv2_d = inv2_q;   tag2_d = tag2_q;
    x0_re_d = x0_re_q; x0_im_d = x0_im_q;
    m_re_d = m_re_q;   m_im_d = m_im_q;
    v3_d = v3_q;   inv3_d = inv3_q;   tag3_d = tag3_q;
    o1_re_d = o1_re_q; o1_im_d = o1_im_q;
    o2_re_d = o2_re_q; o2_im_d = o2_im_q;
    o3_re_d = o3_re_q; o3_im_d = o3_im_q;
    if (en) begin
      v1_d = di_vld;
      if (di_vld) begin
        inv1_d  = di_inv;
        tag1_d  = di_tag;
        a1_re_d = a_re;
        a1_im_d = a_im;
        s1_re_d = b_re + c_re;
        s1_im_d = b_im + c_im;
        d1_re_d = b_re - c_re;
        d1_im_d = b_im - c_im;
      end
      v2_d = v1_q;  inv2_d = inv1_q;  tag2_d = tag1_q;
      x0_re_d = a1_re_q + s1_re_q;
      x0_im_d = a1_im_q + s1_im_q;
      m_re_d  = a1_re_q - (s1_re_q >>> 1);
      m_im_d  = a1_im_q - (s1_im_q >>> 1);
      v3_d = v2_q;  inv3_d = inv2_q;  tag3_d = tag2_q;
      o1_re_d = x0_re_q;
      o1_im_d = x0_im_q;
      if (inv2_q) begin
        o2_re_d = f2_re; o2_im_d = f2_im;
        o3_re_d = f1_re; o3_im_d = f1_im;
      end else begin
        o2_re_d = f1_re; o2_im_d = f1_im;
        o3_re_d = f2_re; o3_im_d = f2_im;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1_q <= 1'b0; inv1_q <= 1'b0; tag1_q <= '0;
      a1_re_q <= '0; a1_im_q <= '0; s1_re_q <= '0; s1_im_q <= '0;
      d1_re_q <= '0; d1_im_q <= '0;
      v2_q <= 1'b0; inv2_q <= 1'b0; tag2_q <= '0;
      x0_re_q <= '0; x0_im_q <= '0; m_re_q <= '0; m_im_q <= '0;
      v3_q <= 1'b0; inv3_q <= 1'b0; tag3_q <= '0;
      o1_re_q <= '0; o1_im_q <= '0; o2_re_q <= '0; o2_im_q <= '0;
      o3_re_q <= '0; o3_im_q <= '0;
    end else begin
      v1_q <= v1_d; inv1_q <= inv1_d; tag1_q <= tag1_d;
      a1_re_q <= a1_re_d; a1_im_q <= a1_im_d; s1_re_q <= s1_re_d; s1_im_q <= s1_im_d;
      d1_re_q <= d1_re_d; d1_im_q <= d1_im_d;
      v2_q <= v2_d; inv2_q <= inv2_d; tag2_q <= tag2_d;
      x0_re_q <= x0_re_d; x0_im_q <= x0_im_d; m_re_q <= m_re_d; m_im_q <= m_im_d;
      v3_q <= v3_d; inv3_q <= inv3_d; tag3_q <= tag3_d;
      o1_re_q <= o1_re_d; o1_im_q <= o1_im_d; o2_re_q <= o2_re_d; o2_im_q <= o2_im_d;
      o3_re_q <= o3_re_d; o3_im_q <= o3_im_d;
    end
  end

  assign do_vld  = v3_q;
  assign do_inv  = inv3_q;
  assign do_tag  = tag3_q;
  assign out1_re = o1_re_q;
  assign out1_im = o1_im_q;
  assign out2_re = o2_re_q;
  assign out2_im = o2_im_q;
  assign out3_re = o3_re_q;
  assign out3_im = o3_im_q;

endmodule

// File: tb/tb_rd3bf_pipe.sv
// Bench for rd3bf_pipe: table vectors, random streams vs. an arithmetic DFT model, stall and reset sequences.
module tb_rd3bf_pipe;

  localparam int DW   = 13;
  localparam int OW   = 15;
  localparam int TW   = 4;
  localparam int OUTW = 6 * OW + 1 + TW;

  logic clk = 1'b0;
  logic n_rst;
  logic di_vld, di_rdy, di_inv;
  logic [TW-1:0] di_tag;
  logic [DW-1:0] in1_re, in1_im, in2_re, in2_im, in3_re, in3_im;
  logic [OW-1:0] out1_re, out1_im, out2_re, out2_im, out3_re, out3_im;
  logic do_vld, do_rdy, do_inv;
  logic [TW-1:0] do_tag;

  always #5 clk = ~clk;

  rd3bf_pipe dut (
    .clk(clk), .n_rst(n_rst),
    .di_vld(di_vld), .di_rdy(di_rdy), .di_inv(di_inv), .di_tag(di_tag),
    .in1_re(in1_re), .in1_im(in1_im), .in2_re(in2_re), .in2_im(in2_im),
    .in3_re(in3_re), .in3_im(in3_im),
    .out1_re(out1_re), .out1_im(out1_im), .out2_re(out2_re), .out2_im(out2_im),
    .out3_re(out3_re), .out3_im(out3_im),
    .do_vld(do_vld), .do_rdy(do_rdy), .do_inv(do_inv), .do_tag(do_tag)
  );

  int tests = 0;
  int fails = 0;
  logic [OUTW-1:0] exp_q[$];
  logic [OUTW-1:0] act;
  bit rnd_done;

  assign act = {out1_re, out1_im, out2_re, out2_im, out3_re, out3_im, do_inv, do_tag};

  typedef struct {
    int ar, ai, br, bi, cr, ci;
    bit inv;
    logic [TW-1:0] tag;
    int x0r, x0i, x1r, x1i, x2r, x2i;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [OUTW-1:0] a, input logic [OUTW-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  task automatic check1(input string name, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, a, e);
    end
  endtask

  function automatic logic [OUTW-1:0] pk(input int x0r, input int x0i, input int x1r,
                                         input int x1i, input int x2r, input int x2i,
                                         input bit inv, input logic [TW-1:0] tag);
    return {15'(x0r), 15'(x0i), 15'(x1r), 15'(x1i), 15'(x2r), 15'(x2i), inv, tag};
  endfunction

  function automatic int fdiv(input int x, input int n);
    if (x >= 0) return x / n;
    return -((-x + n - 1) / n);
  endfunction

  // Reference 3-point DFT: X0 = a+b+c, X1/X2 = a - (b+c)/2 -/+ j*sqrt(3)/2*(b-c).
  function automatic logic [OUTW-1:0] model(input int ar, input int ai, input int br, input int bi,
                                            input int cr, input int ci, input bit inv,
                                            input logic [TW-1:0] tag);
    int sr, si, dr, di, mr, mi, tr, ti;
    sr = br + cr;  si = bi + ci;
    dr = br - cr;  di = bi - ci;
    mr = ar - fdiv(sr, 2);
    mi = ai - fdiv(si, 2);
    tr = fdiv(dr * 887 + 512, 1024);
    ti = fdiv(di * 887 + 512, 1024);
    if (!inv) return pk(ar + sr, ai + si, mr + ti, mi - tr, mr - ti, mi + tr, inv, tag);
    return pk(ar + sr, ai + si, mr - ti, mi + tr, mr + ti, mi - tr, inv, tag);
  endfunction

  function automatic int rs();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // Scoreboard: every output transfer pops one expected beat.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && do_vld === 1'b1 && do_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h want none", act);
      end else begin
        check("out", act, exp_q.pop_front());
      end
    end
  end

  task automatic send(input int ar, input int ai, input int br, input int bi, input int cr,
                      input int ci, input bit inv, input logic [TW-1:0] tag,
                      input logic [OUTW-1:0] e);
    int n;
    n = 0;
    in1_re = 13'(ar); in1_im = 13'(ai);
    in2_re = 13'(br); in2_im = 13'(bi);
    in3_re = 13'(cr); in3_im = 13'(ci);
    di_inv = inv; di_tag = tag; di_vld = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (di_rdy !== 1'b1 && n < 50);
    if (di_rdy !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got di_rdy=%b want 1", di_rdy);
      di_vld = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1 di_vld = 1'b0;
  endtask

  task automatic send_rand(input bit inv, input logic [TW-1:0] tag);
    int ar, ai, br, bi, cr, ci;
    ar = rs(); ai = rs(); br = rs(); bi = rs(); cr = rs(); ci = rs();
    send(ar, ai, br, bi, cr, ci, inv, tag, model(ar, ai, br, bi, cr, ci, inv, tag));
  endtask

  task automatic latency_check();
    @(posedge clk); #1 check1("lat_early", do_vld, 1'b0);
    @(posedge clk); #1 check1("lat_3cyc", do_vld, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain_check(input string name);
    repeat (6) @(posedge clk);
    #1 check1(name, exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{64, 64, 64, 64, 64, 64, 1'b0, 4'd3, 192, 192, 0, 0, 0, 0};
    vt[1] = '{0, 0, 64, 0, 0, 0, 1'b0, 4'd5, 64, 0, -32, -55, -32, 55};
    vt[2] = '{0, 0, 64, 0, 0, 0, 1'b1, 4'd6, 64, 0, -32, 55, -32, -55};
    vt[3] = '{-4096, -4096, 4095, 4095, 4095, 4095, 1'b0, 4'd9, 4094, 4094, -8191, -8191, -8191, -8191};
    vt[4] = '{-4096, -4096, -4096, -4096, -4096, -4096, 1'b0, 4'd10, -12288, -12288, 0, 0, 0, 0};
    vt[5] = '{0, 0, 0, 0, 64, 0, 1'b0, 4'd12, 64, 0, -32, 55, -32, -55};
    vt[6] = '{0, 0, 0, 64, 0, 0, 1'b0, 4'd13, 0, 64, 55, -32, -55, -32};

    n_rst = 1'b0; di_vld = 1'b0; di_inv = 1'b0; di_tag = '0; do_rdy = 1'b1; rnd_done = 1'b0;
    in1_re = '0; in1_im = '0; in2_re = '0; in2_im = '0; in3_re = '0; in3_im = '0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check1("rst_vld", do_vld, 1'b0);
    check("rst_out", act, '0);
    check1("rst_rdy", di_rdy, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      send(vt[i].ar, vt[i].ai, vt[i].br, vt[i].bi, vt[i].cr, vt[i].ci, vt[i].inv, vt[i].tag,
           pk(vt[i].x0r, vt[i].x0i, vt[i].x1r, vt[i].x1i, vt[i].x2r, vt[i].x2i, vt[i].inv, vt[i].tag));
      latency_check();
    end
    drain_check("table_drain");

    // Back-to-back stream of 8 beats.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(1'($urandom_range(0, 1)), 4'(i));
      end
      begin
        int n;
        n = 0;
        while (do_vld !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 8; k++) begin
          check1("b2b_vld", do_vld, 1'b1);
          @(negedge clk);
        end
      end
    join
    drain_check("b2b_drain");

    // Output stall while six tagged beats stream in.
    fork
      begin
        for (int i = 1; i <= 6; i++) send_rand(1'($urandom_range(0, 1)), 4'(i));
      end
      begin
        int n;
        logic [OUTW-1:0] snap;
        n = 0;
        while (do_vld !== 1'b1 && n < 30) begin
          @(posedge clk); #1;
          n++;
        end
        check1("bp_first", do_vld, 1'b1);
        do_rdy = 1'b0;
        snap = act;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check1("bp_rdy", di_rdy, 1'b0);
          check1("bp_vld", do_vld, 1'b1);
          check("bp_hold", act, snap);
        end
        @(posedge clk); #1 do_rdy = 1'b1;
      end
    join
    drain_check("bp_drain");

    // Random stream under random output backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1 do_rdy = ($urandom_range(0, 3) != 0);
        end
        do_rdy = 1'b1;
      end
    join
    drain_check("rnd_drain");

    // Reset with two beats in flight.
    send_rand(1'b0, 4'd1);
    send_rand(1'b1, 4'd2);
    n_rst = 1'b0;
    #1;
    check1("mid_rst_vld", do_vld, 1'b0);
    check("mid_rst_out", act, '0);
    check1("mid_rst_rdy", di_rdy, 1'b1);
    exp_q.delete();
    @(posedge clk); #1 n_rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check1("rst_nostale", do_vld, 1'b0);
    end
    @(posedge clk); #1;
    send_rand(1'b1, 4'd7);
    latency_check();
    drain_check("rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rd3bf_pipe.md
Name: rd3bf_pipe

Overview:
- Parametrised, pipelined successor to the single-shot radix-3 butterfly (rd3bf).
- Computes the 3-point DFT of three complex signed fixed-point samples per beat.
- Beats can be issued back-to-back.
- Per-beat forward/inverse mode select, valid/ready backpressure, and a user tag carried alongside each beat.
- Sits between the radix-3 stage memory reader and the twiddle multiplier in the mixed-radix FFT/IFFT datapath.

Parameters:
- SIGN_BIT, 1, sign bits of the input format.
- INT_BIT, 6, integer bits of the input format.
- FLT_BIT, 6, fractional bits of the input format.
- COEF_FRAC, 10, fractional bits of the √3/2 constant.
- TAG_W, 4, width of the side-band tag carried with each beat.

Derived constants:
- DW = SIGN_BIT+INT_BIT+FLT_BIT (13).
- OW = DW+2 (15).

Ports:
- clk, in, 1, clock.
- n_rst, in, 1, reset, asynchronous, active-low.
- di_vld, in, 1, input beat valid.
- di_rdy, out, 1, block accepts a beat this cycle.
- di_inv, in, 1, 0 = forward DFT, 1 = inverse (unscaled) for this beat.
- di_tag, in, TAG_W, side-band tag for this beat.
- in1_re, in1_im, in2_re, in2_im, in3_re, in3_im, in, DW each, two's-complement inputs a, b, c.
- out1_re … out3_im, out, OW each, two's-complement outputs X0, X1, X2.
- do_vld, out, 1, output beat valid.
- do_rdy, in, 1, downstream accepts the output beat.
- do_inv, out, 1, mode of the output beat.
- do_tag, out, TAG_W, tag of the output beat.

Behaviour:
- Reset: clk is the only clock; n_rst is asynchronous and active-low. All stage-valid bits, data, tag and mode registers clear to 0. So do_vld=0, all outputs 0, do_inv=0, do_tag=0, and di_rdy=1 after reset.
- Handshake:
  - Input transfer occurs when di_vld & di_rdy.
  - Output transfer occurs when do_vld & do_rdy.
  - Pipeline enable is en = ~do_vld | do_rdy, and di_rdy = en.
  - With en=0 every stage holds, including bubbles; bubbles are not collapsed.
  - do_* are stable while do_vld=1 & do_rdy=0.
- Latency and throughput: 3 cycles from accepted input to do_vld; 1 beat/cycle when do_rdy stays high.
- S1 (sign-extend all operands to OW bits):
  - s = b+c, d = b-c, register a.
  - Tag and inv travel in a parallel shift path.
- S2:
  - X0 = a+s.
  - m = a - (s>>>1), arithmetic shift with floor.
  - p = C·d for re and im, with C = round(√3/2·2^COEF_FRAC) = 887 at default.
- S3:
  - t = (p + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up).
  - Forward: X1 = (m_re+t_im, m_im−t_re) and X2 = (m_re−t_im, m_im+t_re).
  - Inverse: X1 and X2 swap.
  - Output registers load.
- Widths: OW bits hold every result for all DW-bit inputs, so there is no saturation or wrap. Product width is OW+COEF_FRAC+1.
- Simultaneous events: an input accepted in the same cycle as an output drains is a normal case; throughput is preserved.
- di_inv and di_tag are sampled only on an accepted beat.
- Reset mid-operation: in-flight beats are discarded immediately and no partial output appears. The first beat after release emerges 3 cycles after its acceptance.

Decomposition:
- Package rd3_pkg holds:
  - Width functions DW/OW.
  - Constant C_SQ3H (887) derived from COEF_FRAC.
  - Rounding offset constant.
- One sub-module, rd3_const_mult: signed OW-bit × C_SQ3H with round-half-up shift. It is instantiated twice (re, im), pipelined across S2/S3 with the same enable.

Test Plan:
- All-equal input: a=b=c=64+64j LSB (1+1j), forward, do_rdy=1 → X0=192+192j, X1=X2=0+0j, do_vld exactly 3 cycles after acceptance, tag echoed.
- Unit input: a=0, b=64+0j, c=0.
  - Forward → X0=64+0j, X1=−32−55j, X2=−32+55j.
  - Same data with di_inv=1 → X1=−32+55j, X2=−32−55j, do_inv=1.
- Boundary: a=−4096 all parts, b=c=4095.
  - Expected X0=4094, X1=X2=−8191 on both re and im (d=0, so t=0).
  - Also run a=b=c=−4096 → X0=−12288, X1=X2=0, with no wrap.
- Backpressure: stream 6 beats with tags 1..6 and hold do_rdy=0 from the cycle the first output appears for 4 cycles.
  - di_rdy drops while the output is stalled.
  - The output holds stable.
  - All 6 results emerge in tag order with none lost or duplicated.
- Back-to-back stream: 8 consecutive beats with do_rdy=1 → 8 consecutive do_vld cycles, each matching a reference model bit-exactly.
- Reset mid-stream: assert n_rst low for 1 cycle with 2 beats in flight → do_vld=0 and outputs 0 immediately. A fresh beat after release produces correct output 3 cycles later, and no stale beat appears.
